// File: rtl/cpu_trace_buffer_pkg.sv
// Shared definitions for the CPU trace buffer: state and trigger-mode encodings
// and the packed entry width helper.
package cpu_trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    TRIG_IMM = 2'd0,
    TRIG_PC  = 2'd1,
    TRIG_ALU = 2'd2,
    TRIG_EXT = 2'd3
  } trig_mode_t;

  // One trace entry packs {pc, instr, alu}.
  function automatic int entry_w(input int data_w);
    return 3 * data_w;
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// Simple dual-port trace storage: one synchronous write port and one registered
// read port that returns pre-write data on an address collision.
module trace_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int WIDTH  = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              rclr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it can map onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else       rdata <= rclr ? '0 : mem[raddr];
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Execution trace capture for the brain CPU: circular {pc, instr, alu} buffer
// with a selectable trigger, clamped post-trigger window and logical readout.
module cpu_trace_buffer
  import cpu_trace_buffer_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cap_valid,
  input  logic [DATA_W-1:0]   cap_pc,
  input  logic [DATA_W-1:0]   cap_instr,
  input  logic [DATA_W-1:0]   cap_alu,
  input  logic                arm,
  input  logic [1:0]          trig_mode,
  input  logic [DATA_W-1:0]   trig_value,
  input  logic                trig_ext,
  input  logic [ADDR_W:0]     post_count,
  output logic [1:0]          state,
  output logic                done,
  output logic                wrapped,
  output logic [ADDR_W:0]     entry_count,
  output logic [ADDR_W-1:0]   trig_index,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [3*DATA_W-1:0] rd_data
);

  localparam int ENTRY_W = entry_w(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            st;
  logic [ADDR_W-1:0] wr_ptr, trig_phys, remaining;
  logic              capturing, hit, wrap_next, rclr;
  logic [ADDR_W-1:0] ptr_next, start, start_next, post_clamped, final_phys, raddr;

  assign state     = st;
  assign capturing = !arm && cap_valid && (st == ST_PRE || st == ST_POST);
  assign ptr_next  = wr_ptr + ADDR_W'(1);
  assign wrap_next = wrapped || (wr_ptr == LAST_PTR);
  assign start     = wrapped ? wr_ptr : '0;
  assign start_next = wrap_next ? ptr_next : '0;
  assign final_phys = (st == ST_PRE) ? wr_ptr : trig_phys;
  assign raddr      = start + rd_addr;
  assign rclr       = ({1'b0, rd_addr} >= entry_count);

  // Never keep more post-trigger samples than would overwrite the trigger entry.
  assign post_clamped = (post_count > (ADDR_W+1)'(DEPTH - 1)) ? LAST_PTR
                                                              : post_count[ADDR_W-1:0];

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    hit = 1'b0;
    case (trig_mode_t'(trig_mode))
      TRIG_IMM: hit = 1'b1;
      TRIG_PC:  hit = (cap_pc == trig_value);
      TRIG_ALU: hit = (cap_alu == trig_value);
      TRIG_EXT: hit = trig_ext;
      default:  hit = 1'b0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= ST_IDLE;
      wr_ptr      <= '0;
      entry_count <= '0;
      wrapped     <= 1'b0;
      trig_phys   <= '0;
      remaining   <= '0;
      trig_index  <= '0;
      done        <= 1'b0;
    end else if (arm) begin
      st          <= ST_PRE;
      wr_ptr      <= '0;
      entry_count <= '0;
      wrapped     <= 1'b0;
      remaining   <= '0;
      trig_index  <= '0;
      done        <= 1'b0;
    end else if (capturing) begin
      wr_ptr  <= ptr_next;
      wrapped <= wrap_next;
      if (entry_count != (ADDR_W+1)'(DEPTH)) entry_count <= entry_count + (ADDR_W+1)'(1);
      if (st == ST_PRE) begin
        if (hit) begin
          trig_phys <= wr_ptr;
          remaining <= post_clamped;
          if (post_clamped == '0) begin
            st         <= ST_DONE;
            done       <= 1'b1;
            trig_index <= final_phys - start_next;
          end else begin
            st <= ST_POST;
          end
        end
      end else begin
        remaining <= remaining - ADDR_W'(1);
        if (remaining == ADDR_W'(1)) begin
          st         <= ST_DONE;
          done       <= 1'b1;
          trig_index <= final_phys - start_next;
        end
      end
    end
  end

  trace_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (capturing),
    .waddr (wr_ptr),
    .wdata ({cap_pc, cap_instr, cap_alu}),
    .raddr (raddr),
    .rclr  (rclr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: table-driven capture scenarios plus
// hand-written arm, reset, trigger-gating and readout corner cases.
module tb_cpu_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cap_valid;
  logic [15:0] cap_pc, cap_instr, cap_alu;
  logic        arm;
  logic [1:0]  trig_mode;
  logic [15:0] trig_value;
  logic        trig_ext;
  logic [5:0]  post_count;
  logic [1:0]  state;
  logic        done, wrapped;
  logic [5:0]  entry_count;
  logic [4:0]  trig_index;
  logic [4:0]  rd_addr;
  logic [47:0] rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_trace_buffer #(.DATA_W(16), .DEPTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .cap_valid  (cap_valid),
    .cap_pc     (cap_pc),
    .cap_instr  (cap_instr),
    .cap_alu    (cap_alu),
    .arm        (arm),
    .trig_mode  (trig_mode),
    .trig_value (trig_value),
    .trig_ext   (trig_ext),
    .post_count (post_count),
    .state      (state),
    .done       (done),
    .wrapped    (wrapped),
    .entry_count(entry_count),
    .trig_index (trig_index),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [15:0] tval;
    logic [5:0]  post;
    int          step;
    bit          toggle;
    int          exp_cycles;
    int          exp_entries;
    int          exp_tidx;
    bit          exp_wrapped;
    logic [15:0] trig_pc;
    logic [4:0]  rd;
    logic [15:0] rd_pc;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] entry_of(input logic [15:0] pc);
    return {pc, pc ^ 16'hA5A5, pc + 16'h0100};
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic drive(input bit v, input logic [15:0] pc);
    cap_valid = v;
    cap_pc    = pc;
    cap_instr = pc ^ 16'hA5A5;
    cap_alu   = pc + 16'h0100;
    @(posedge clk);
    @(negedge clk);
    cap_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic read_entry(input logic [4:0] a, output logic [47:0] d);
    rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    d = rd_data;
  endtask

  initial begin
    logic [47:0] d;
    int cyc, k;
    bit v;

    vecs[0] = '{"imm",    2'd0, 16'h0000, 6'd3,  1, 1'b0,  4,  4,  0, 1'b0, 16'h0000, 5'd0,  16'h0000};
    vecs[1] = '{"pcmatch",2'd1, 16'h0024, 6'd4,  2, 1'b0, 23, 23, 18, 1'b0, 16'h0024, 5'd22, 16'h002C};
    vecs[2] = '{"wrap",   2'd1, 16'h0064, 6'd8,  2, 1'b0, 59, 32, 23, 1'b1, 16'h0064, 5'd0,  16'h0036};
    vecs[3] = '{"clamp",  2'd0, 16'h0000, 6'd40, 1, 1'b1, 63, 32,  0, 1'b1, 16'h0000, 5'd31, 16'h001F};
    vecs[4] = '{"alumatch",2'd2,16'h0105, 6'd2,  1, 1'b0,  8,  8,  5, 1'b0, 16'h0005, 5'd7,  16'h0007};

    reset = 1'b1; arm = 1'b0; cap_valid = 1'b0; cap_pc = '0; cap_instr = '0; cap_alu = '0;
    trig_mode = '0; trig_value = '0; trig_ext = 1'b0; post_count = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_state", state, 2'd0);
    check("rst_done", done, 1'b0);
    check("rst_wrapped", wrapped, 1'b0);
    check("rst_entries", entry_count, 6'd0);
    check("rst_tidx", trig_index, 5'd0);
    check("rst_rdata", rd_data, 48'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      trig_mode  = vecs[i].mode;
      trig_value = vecs[i].tval;
      post_count = vecs[i].post;
      do_arm();
      check({vecs[i].name, "_armed"}, state, 2'd1);
      cyc = 0;
      k   = 0;
      while (cyc < 200 && !done) begin
        v = vecs[i].toggle ? (cyc % 2 == 0) : 1'b1;
        drive(v, v ? 16'(k * vecs[i].step) : 16'hFFFF);
        if (v) k++;
        cyc++;
      end
      check({vecs[i].name, "_done"}, done, 1'b1);
      check({vecs[i].name, "_state"}, state, 2'd3);
      check({vecs[i].name, "_cycles"}, cyc, vecs[i].exp_cycles);
      check({vecs[i].name, "_entries"}, entry_count, vecs[i].exp_entries);
      check({vecs[i].name, "_tidx"}, trig_index, vecs[i].exp_tidx);
      check({vecs[i].name, "_wrapped"}, wrapped, vecs[i].exp_wrapped);
      read_entry(5'(vecs[i].exp_tidx), d);
      check({vecs[i].name, "_trig_entry"}, d, entry_of(vecs[i].trig_pc));
      read_entry(vecs[i].rd, d);
      check({vecs[i].name, "_rd"}, d, entry_of(vecs[i].rd_pc));
    end

    // External trigger is ignored on cycles without a valid sample.
    trig_mode = 2'd3; post_count = 6'd0;
    do_arm();
    trig_ext = 1'b1;
    repeat (3) drive(1'b0, 16'h0BAD);
    check("ext_novalid_state", state, 2'd1);
    check("ext_novalid_entries", entry_count, 6'd0);
    trig_ext = 1'b0;
    drive(1'b1, 16'h0010);
    check("ext_low_state", state, 2'd1);
    trig_ext = 1'b1;
    drive(1'b1, 16'h0011);
    trig_ext = 1'b0;
    check("ext_state", state, 2'd3);
    check("ext_entries", entry_count, 6'd2);
    check("ext_tidx", trig_index, 5'd1);

    // Reads at or beyond entry_count return zero.
    read_entry(5'd2, d);
    check("oob_rd2", d, 48'd0);
    read_entry(5'd1, d);
    check("inb_rd1", d, entry_of(16'h0011));
    read_entry(5'd31, d);
    check("oob_rd31", d, 48'd0);

    // Read-before-write: oldest slot after a wrap is the one being written next.
    trig_mode = 2'd1; trig_value = 16'hFFFF;
    do_arm();
    for (int j = 0; j < 33; j++) drive(1'b1, 16'(j));
    check("rbw_wrapped", wrapped, 1'b1);
    check("rbw_entries", entry_count, 6'd32);
    rd_addr = 5'd0;
    drive(1'b1, 16'd33);
    check("rbw_old_data", rd_data, entry_of(16'd1));

    // arm in the middle of POST restarts capture, sample on the arm cycle dropped.
    trig_mode = 2'd0; post_count = 6'd10;
    do_arm();
    repeat (3) drive(1'b1, 16'h0020);
    check("midpost_state", state, 2'd2);
    arm = 1'b1;
    drive(1'b1, 16'h0021);
    arm = 1'b0;
    check("rearm_state", state, 2'd1);
    check("rearm_entries", entry_count, 6'd0);

    // Asynchronous reset in the middle of POST, checked before any clock edge.
    repeat (2) drive(1'b1, 16'h0030);
    check("prereset_state", state, 2'd2);
    #2 reset = 1'b1;
    #1;
    check("areset_state", state, 2'd0);
    check("areset_done", done, 1'b0);
    check("areset_entries", entry_count, 6'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Parametrised on-chip execution trace capture for the brain CPU. It is the synthesizable successor to the bench's live PC/Instr/ALU monitoring. Each qualified cycle it records {pc, instruction, alu_out} into a circular buffer, stops a programmable number of samples after a selectable trigger, and supports random-access readout for debug logic or a host interface. It sits beside brain and taps its datapath signals.

Parameters:
DATA_W, 16, width of each captured field (pc, instruction, alu_out).
DEPTH, 32, number of trace entries; power of 2, minimum 4.
ADDR_W, $clog2(DEPTH), entry index width (derived; not overridden).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cap_valid  in  1  sample qualifier (one retired instruction)
cap_pc  in  DATA_W  program counter sample
cap_instr  in  DATA_W  instruction sample
cap_alu  in  DATA_W  ALU result sample
arm  in  1  single-cycle arm/restart pulse
trig_mode  in  2  0=immediate, 1=pc match, 2=alu match, 3=external
trig_value  in  DATA_W  compare value for modes 1 and 2
trig_ext  in  1  external trigger (mode 3)
post_count  in  ADDR_W+1  samples captured after the trigger sample
state  out  2  0=IDLE, 1=PRE, 2=POST, 3=DONE
done  out  1  high in DONE
wrapped  out  1  buffer has overwritten its oldest entry
entry_count  out  ADDR_W+1  valid entries, 0..DEPTH
trig_index  out  ADDR_W  logical index of the trigger entry (valid when done)
rd_addr  in  ADDR_W  logical read index, 0 = oldest
rd_data  out  3*DATA_W  {pc, instr, alu}, registered

Behaviour:
- Reset (async): state=IDLE, done=0, wrapped=0, entry_count=0, trig_index=0, rd_data=0, write pointer=0. RAM contents are not reset.
- arm=1 in any state, next edge:
  - state goes to PRE.
  - Write pointer, entry_count, wrapped and trig_index are cleared.
  - Any in-progress capture is abandoned.
  - arm has priority over every same-cycle event; the sample on an arm cycle is not written.
- IDLE/DONE: no writes, and cap_valid is ignored.
- PRE: each cap_valid cycle writes an entry at the write pointer, then:
  - pointer increments modulo DEPTH;
  - entry_count saturates at DEPTH;
  - wrapped sets when the pointer wraps from DEPTH-1 to 0.
- Trigger condition is evaluated only on a cap_valid cycle in PRE:
  - mode 0: always true;
  - mode 1: cap_pc==trig_value;
  - mode 2: cap_alu==trig_value;
  - mode 3: trig_ext==1.
- Trigger cycle:
  - The trigger sample is written.
  - Its physical address is latched.
  - Remaining count is loaded with min(post_count, DEPTH-1); the clamp guarantees the trigger entry survives.
  - If the loaded value is 0, next state is DONE; otherwise POST.
  - post_count and trig_mode are sampled only at this point.
- POST: each cap_valid writes an entry and decrements the remaining count. When the count reaches 0 after the write, next state is DONE. Cycles with cap_valid=0 neither write nor decrement.
- DONE:
  - done=1.
  - trig_index = (trig_phys - start) mod DEPTH, where start = wrapped ? write pointer : 0.
  - Stays in DONE until arm or reset.
- Readout:
  - Physical address = (start + rd_addr) mod DEPTH.
  - rd_data updates one cycle after rd_addr and is legal in every state.
  - rd_addr >= entry_count returns 0.
  - A read of the address being written in the same cycle returns the old data (read-before-write).
- Reset asserted mid-capture returns the block to IDLE immediately.

Decomposition:
- Shared package:
  - state encoding constants (IDLE/PRE/POST/DONE);
  - trig_mode constants;
  - ENTRY_W = 3*DATA_W helper.
- One natural sub-module, trace_ram: simple dual-port RAM, DEPTH x ENTRY_W, with one synchronous write port and one registered read port.
- The controller (FSM, pointers, counters, trigger compare, address translation) stays in cpu_trace_buffer.

Test Plan:
- Immediate mode, post_count=3, pc=0,1,2,… with cap_valid every cycle -> DONE after 4 samples; entry_count=4, trig_index=0, wrapped=0; rd_addr=0 gives pc=0x0000 one cycle later.
- PC match trig_value=0x0024, post_count=4, pc steps by 2 from 0 -> trigger on sample 18; entry_count=23, trig_index=18, rd_addr=22 gives pc=0x002C.
- Wrap: PC match 0x0064, post_count=8, pc steps by 2 -> 59 writes; wrapped=1, entry_count=32; rd_addr=0 gives pc=0x0036; trig_index=23; rd_addr=23 gives pc=0x0064.
- Clamp and gaps: immediate mode, post_count=40, cap_valid toggling 1/0 -> clamped to 31, so DONE after 32 valid samples (63 cycles); trig_index=0 and the entry at rd_addr=0 is the trigger sample; invalid cycles leave entry_count unchanged.
- Control edges:
  - Mode 3 with trig_ext=1 while cap_valid=0 -> no trigger.
  - arm pulsed mid-POST -> state=PRE next cycle, entry_count=0.
  - reset asserted mid-POST -> state=IDLE, done=0, entry_count=0 with no clock edge required.
  - rd_addr >= entry_count -> rd_data=0.
